// File: rtl/mem_bus_iface_if.sv
// Request, status and memory-side signals of mem_bus_iface; slave = the bus engine, master = CPU/memory side.
interface mem_bus_iface_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  req;
   logic                  req_we;
   logic [1:0]            req_size;
   logic                  req_signed;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [DATA_W-1:0]     rdata;
   logic                  cs;
   logic                  we;
   logic                  oe;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W/8-1:0]   byte_en;
   logic [DATA_W-1:0]     ram_data_in;
   logic [DATA_W-1:0]     ram_data_out;
   logic                  ram_ready;

   modport slave (
      input  req, req_we, req_size, req_signed, req_addr, req_wdata,
      input  ram_data_out, ram_ready,
      output busy, done, err, rdata,
      output cs, we, oe, address, byte_en, ram_data_in
   );

   modport master (
      output req, req_we, req_size, req_signed, req_addr, req_wdata,
      output ram_data_out, ram_ready,
      input  busy, done, err, rdata,
      input  cs, we, oe, address, byte_en, ram_data_in
   );
endinterface

// File: rtl/mem_bus_iface.sv
// One load/store at a time: req -> done in 3 cycles minimum plus wait states; req ignored while busy, ram_ready waits up to TIMEOUT.
// ARM_UNALIGNED_ROTATE_EN: misaligned 32-bit word loads read the aligned word and rotate instead of faulting.
module mem_bus_iface #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           rst,
   mem_bus_iface_if.slave bus
);
   localparam int LANES = DATA_W / 8;
   localparam int LB    = $clog2(LANES);
   localparam int SH_W  = LB + 3;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TIMEOUT);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LANES - 1);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WAIT, S_DONE, S_FAULT} state_t;

   state_t              r_state;
   logic                r_req_we;
   logic                r_signed;
   logic [1:0]          r_size;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_busy;
   logic                r_done;
   logic                r_err;
   logic                r_cs;
   logic                r_we;
   logic                r_oe;
   logic [ADDR_W-1:0]   r_address;
   logic [LANES-1:0]    r_byte_en;
   logic [DATA_W-1:0]   r_ram_data_in;
   logic [DATA_W-1:0]   r_rdata;

   logic [LB-1:0]       w_off;
   logic [SH_W-1:0]     w_shamt;
   logic                w_misaligned;
   logic                w_size_ok;
   logic                w_rotate;
   logic                w_fault;
   logic [LANES-1:0]    w_byte_en;
   logic [DATA_W-1:0]   w_rd_src;
   logic [DATA_W-1:0]   w_mask;
   logic                w_sbit;
   logic [DATA_W-1:0]   w_load;

   assign w_off     = r_addr[LB-1:0];
   assign w_shamt   = {w_off, 3'b000};
   assign w_size_ok = (r_size != 2'b11) || (DATA_W == 64);

`ifdef ARM_UNALIGNED_ROTATE_EN
   // ARMv4 LDR: fetch the aligned word, rotate the addressed byte down to lane 0
   assign w_rotate = (DATA_W == 32) && (r_size == 2'b10) && !r_req_we;
   assign w_rd_src = w_rotate
                   ? ((bus.ram_data_out >> w_shamt) | (bus.ram_data_out << (DATA_W - int'(w_shamt))))
                   : (bus.ram_data_out >> w_shamt);
`else
   assign w_rotate = 1'b0;
   assign w_rd_src = bus.ram_data_out >> w_shamt;
`endif

   always_comb begin
      case (r_size)
         2'b00:   w_misaligned = 1'b0;
         2'b01:   w_misaligned = w_off[0];
         2'b10:   w_misaligned = |w_off[1:0];
         default: w_misaligned = |w_off;
      endcase
   end

   assign w_fault = !w_size_ok || (w_misaligned && !w_rotate);

   always_comb begin
      w_byte_en = '1;
      w_mask    = '1;
      w_sbit    = 1'b0;
      case (r_size)
         2'b00: begin
            w_byte_en = LANES'(1) << w_off;
            w_mask    = DATA_W'(8'hFF);
            w_sbit    = w_rd_src[7];
         end
         2'b01: begin
            w_byte_en = LANES'(3) << w_off;
            w_mask    = DATA_W'(16'hFFFF);
            w_sbit    = w_rd_src[15];
         end
         2'b10: begin
            w_byte_en = w_rotate ? '1 : (LANES'(15) << w_off);
            w_mask    = DATA_W'(32'hFFFF_FFFF);
            w_sbit    = w_rd_src[31];
         end
         default: w_byte_en = '1;
      endcase
   end

   assign w_load = (w_rd_src & w_mask) | ((r_signed && w_sbit) ? ~w_mask : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_req_we      <= 1'b0;
         r_signed      <= 1'b0;
         r_size        <= 2'b00;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_cnt         <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
         r_cs          <= 1'b0;
         r_we          <= 1'b0;
         r_oe          <= 1'b0;
         r_address     <= '0;
         r_byte_en     <= '0;
         r_ram_data_in <= '0;
         r_rdata       <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.req) begin
                  r_req_we <= bus.req_we;
                  r_signed <= bus.req_signed;
                  r_size   <= bus.req_size;
                  r_addr   <= bus.req_addr;
                  r_wdata  <= bus.req_wdata;
                  r_busy   <= 1'b1;
                  r_state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_fault) begin
                  r_err   <= 1'b1;
                  r_state <= S_FAULT;
               end else begin
                  r_cs          <= 1'b1;
                  r_we          <= r_req_we;
                  r_oe          <= !r_req_we;
                  r_address     <= r_addr & ALIGN_MASK;
                  r_byte_en     <= w_byte_en;
                  r_ram_data_in <= r_wdata << w_shamt;
                  r_cnt         <= '0;
                  r_state       <= S_WAIT;
               end
            end
            S_WAIT: begin
               // ready wins over a timeout landing on the same edge
               if (bus.ram_ready) begin
                  r_cs    <= 1'b0;
                  r_we    <= 1'b0;
                  r_oe    <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                  if (!r_req_we) r_rdata <= w_load;
               end else if ((TIMEOUT != 0) && (r_cnt == CNT_MAX)) begin
                  r_cs    <= 1'b0;
                  r_we    <= 1'b0;
                  r_oe    <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= S_FAULT;
               end else if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.err         = r_err;
   assign bus.rdata       = r_rdata;
   assign bus.cs          = r_cs;
   assign bus.we          = r_we;
   assign bus.oe          = r_oe;
   assign bus.address     = r_address;
   assign bus.byte_en     = r_byte_en;
   assign bus.ram_data_in = r_ram_data_in;
endmodule
